shift_seq_unit: RTL
===================

Name: shift_seq_unit

Overview:
- Multi-cycle, handshake-driven shift execution unit for the RV32I ALU path.
- Decodes shift instructions from funct3/funct7/immediate fields: SLL, SLLI, SRL, SRLI, SRA, SRAI.
- Performs the shift iteratively, at most SHIFT_STEP bit positions per cycle, trading latency for area.
- Sits between the decode/issue stage (valid/ready request) and writeback (valid/ready response).

Parameters:
- XLEN, 32: operand and result width; power of two.
- SHIFT_STEP, 4: maximum bit positions shifted per cycle; power of two, 1..XLEN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid from issue.
- req_ready_o  out  1  unit can accept a request.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7 (imm[11:5] for immediate forms).
- is_imm_i  in  1  1 = immediate form (shamt from shamt_imm_i); 0 = register form (shamt from rs2_i).
- shamt_imm_i  in  log2(XLEN)  immediate shift amount.
- rs1_i  in  XLEN  value to shift.
- rs2_i  in  XLEN  register shift source; only bits [log2(XLEN)-1:0] used.
- flush_i  in  1  synchronous abort of any in-flight operation.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  shifted result.
- illegal_o  out  1  request was not a legal shift encoding; qualified by rsp_valid_o.
- busy_o  out  1  state is not IDLE.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Registers: operand, remaining count, direction, arithmetic flag, illegal flag.
- Reset: rst_ni low at a rising edge sets state=IDLE and clears all registers, including mid-operation. Pending results are discarded.
- Output values during and immediately after reset: rsp_valid_o=0, result_o=0, illegal_o=0, busy_o=0. req_ready_o=0 while rst_ni is low.
- req_ready_o = (state==IDLE) && rst_ni. A request is accepted on an edge where req_valid_i && req_ready_o. Request inputs are sampled only at acceptance.
- Decode:
  - funct3=001, funct7=0000000 -> left logical.
  - funct3=101, funct7=0000000 -> right logical.
  - funct3=101, funct7=0100000 -> right arithmetic.
  - Anything else is illegal.
- shamt = is_imm_i ? shamt_imm_i : rs2_i[log2(XLEN)-1:0]. Upper rs2 bits are ignored.
- On acceptance (legal): operand<=rs1_i, remaining<=shamt.
  - If shamt==0, next state is DONE.
  - Otherwise, next state is SHIFT.
- On acceptance (illegal): operand<=0, illegal flag<=1, next state DONE.
- SHIFT: each edge shifts operand by k=min(remaining, SHIFT_STEP) and sets remaining<=remaining-k.
  - Left shift and logical right shift fill vacated bits with 0.
  - Arithmetic right shift fills with the operand's original bit XLEN-1.
  - When the new remaining value is 0, next state is DONE.
- DONE:
  - rsp_valid_o=1; result_o=operand; illegal_o=illegal flag.
  - Outputs are held stable until rsp_valid_o && rsp_ready_i, then state -> IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency: first rsp_valid_o cycle is 1+ceil(shamt/SHIFT_STEP) cycles after the accept cycle. Examples: 1 cycle for shamt=0 or an illegal request; 9 cycles for shamt=31 with SHIFT_STEP=4.
- Outside DONE: rsp_valid_o=0 and illegal_o=0. result_o holds its last value; it has no meaning without rsp_valid_o.
- flush_i: at an edge with flush_i=1, state -> IDLE and illegal flag cleared.
  - No response is produced for the flushed operation.
  - flush_i has priority over acceptance and the response handshake.
  - rst_ni has priority over flush_i.
- busy_o = (state != IDLE).
- Per cycle, the datapath needs only a SHIFT_STEP-range shifter. The full XLEN barrel shifter must not be used.

Test Plan:
- Left shift at maximum distance: SLL, rs1=0x00000001, rs2=0x0000001F, SHIFT_STEP=4 -> result 0x80000000, illegal_o=0. rsp_valid_o first seen 9 cycles after accept; busy_o=1 throughout.
- Arithmetic right shift, immediate form: SRAI, rs1=0x80000000, shamt_imm=4, funct7=0100000 -> 0xF8000000 after 2 cycles. SRLI with the same operands -> 0x08000000.
- Zero shift and ignored rs2 upper bits:
  - SRL, rs1=0xF0000000, rs2=0xFFFFFFE4 (shamt 4) -> 0x0F000000.
  - SLL with rs2=0x00000020 (shamt 0) -> result equals rs1 after 1 cycle.
- Backpressure: rsp_ready_i=0 for 3 cycles in DONE -> rsp_valid_o and result_o stable, req_ready_o=0. A req_valid_i=1 during this time is not accepted. Raising rsp_ready_i -> IDLE next cycle, req_ready_o=1.
- Illegal encodings: funct3=000, or funct3=101 with funct7=0000001 -> rsp_valid_o after 1 cycle, illegal_o=1, result_o=0.
- Abort paths:
  - flush_i pulsed on the 3rd SHIFT cycle of shamt=31 -> IDLE next cycle and no rsp_valid_o.
  - rst_ni=0 mid-SHIFT -> all outputs 0 next cycle. After release, a fresh SLL by 1 of 0x1 returns 0x2.

Source files
------------

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle between issue, the iterative shift unit and writeback.
// master = issue/writeback side, slave = shift unit.
interface shift_seq_unit_if #(
    parameter int XLEN = 32
);
    localparam int SW = $clog2(XLEN);

    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic            is_imm_i;
    logic [SW-1:0]   shamt_imm_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] result_o;
    logic            illegal_o;
    logic            busy_o;

    modport master (
        output req_valid_i, funct3_i, funct7_i, is_imm_i, shamt_imm_i,
               rs1_i, rs2_i, flush_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, illegal_o, busy_o
    );

    modport slave (
        input  req_valid_i, funct3_i, funct7_i, is_imm_i, shamt_imm_i,
               rs1_i, rs2_i, flush_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, illegal_o, busy_o
    );
endinterface

// File: rtl/shift_seq_unit.sv
// Iterative RV32I shift unit: SLL/SRL/SRA (reg and imm forms), shifting at most
// SHIFT_STEP positions per cycle behind a valid/ready request and response.
module shift_seq_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    shift_seq_unit_if.slave   bus
);
    localparam int SW = $clog2(XLEN);
    localparam int KW = SW + 1;
    localparam logic [KW-1:0] STEP_K = KW'(SHIFT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] operand_reg;
    logic [SW-1:0]   remaining_reg;
    logic            left_reg;
    logic            arith_reg;
    logic            illegal_reg;

    logic            dec_left;
    logic            dec_srl;
    logic            dec_sra;
    logic            dec_legal;
    logic [SW-1:0]   req_shamt;
    logic [XLEN-SW-1:0] rs2_unused;

    logic            fill_bit;
    logic [KW-1:0]   step_k;
    logic [SW-1:0]   rem_next;
    logic [XLEN-1:0] operand_next;
    logic [XLEN-1:0] cand [SHIFT_STEP+1];

    assign dec_left  = (bus.funct3_i == 3'b001) && (bus.funct7_i == 7'b0000000);
    assign dec_srl   = (bus.funct3_i == 3'b101) && (bus.funct7_i == 7'b0000000);
    assign dec_sra   = (bus.funct3_i == 3'b101) && (bus.funct7_i == 7'b0100000);
    assign dec_legal = dec_left || dec_srl || dec_sra;

    assign req_shamt  = bus.is_imm_i ? bus.shamt_imm_i : bus.rs2_i[SW-1:0];
    assign rs2_unused = bus.rs2_i[XLEN-1:SW];

    // An arithmetic shift never changes the MSB, so it still holds the original sign.
    assign fill_bit = arith_reg & operand_reg[XLEN-1];

    // One candidate per legal step distance 0..SHIFT_STEP; no full barrel shifter.
    genvar gi;
    generate
        for (gi = 0; gi <= SHIFT_STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign cand[gi] = operand_reg;
            end else if (gi >= XLEN) begin : g_all
                assign cand[gi] = left_reg ? {XLEN{1'b0}} : {XLEN{fill_bit}};
            end else begin : g_part
                assign cand[gi] = left_reg ? {operand_reg[XLEN-1-gi:0], {gi{1'b0}}}
                                           : {{gi{fill_bit}}, operand_reg[XLEN-1:gi]};
            end
        end
    endgenerate

    always_comb begin
        step_k = ({1'b0, remaining_reg} > STEP_K) ? STEP_K : {1'b0, remaining_reg};
        rem_next = remaining_reg - step_k[SW-1:0];
        operand_next = operand_reg;
        for (int i = 0; i <= SHIFT_STEP; i++) begin
            if (step_k == KW'(i)) begin
                operand_next = cand[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            operand_reg   <= '0;
            remaining_reg <= '0;
            left_reg      <= 1'b0;
            arith_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (bus.flush_i) begin
            state_reg   <= ST_IDLE;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        if (dec_legal) begin
                            operand_reg   <= bus.rs1_i;
                            remaining_reg <= req_shamt;
                            left_reg      <= dec_left;
                            arith_reg     <= dec_sra;
                            illegal_reg   <= 1'b0;
                            state_reg     <= (req_shamt == '0) ? ST_DONE : ST_SHIFT;
                        end else begin
                            operand_reg   <= '0;
                            remaining_reg <= '0;
                            left_reg      <= 1'b0;
                            arith_reg     <= 1'b0;
                            illegal_reg   <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    operand_reg   <= operand_next;
                    remaining_reg <= rem_next;
                    if (rem_next == '0) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready_i) begin
                        state_reg   <= ST_IDLE;
                        illegal_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (state_reg == ST_IDLE) && rst_ni;
    assign bus.rsp_valid_o = (state_reg == ST_DONE);
    assign bus.illegal_o   = (state_reg == ST_DONE) && illegal_reg;
    assign bus.busy_o      = (state_reg != ST_IDLE);
    assign bus.result_o    = operand_reg;

endmodule
